// File: rtl/adder_mask_reducer_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_mask_reducer_if
// Description : Batch-in / result-out bus for the CIM adder-mask reducer.
//               Slave is the reducer, master is the batch producer/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_mask_reducer_if #(
    parameter int NUM_MACRO = 16,
    parameter int OUT_CH    = 512,
    parameter int PSUM_W    = 16
);
    localparam int BIT_OUT_CH = $clog2(OUT_CH);
    localparam int ACC_W      = PSUM_W + $clog2(NUM_MACRO);

    // batch input side
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_MACRO*BIT_OUT_CH-1:0] WHICH_FILTER;
    logic [NUM_MACRO*NUM_MACRO-1:0]  Adder_mask;
    logic [NUM_MACRO-1:0]            MACRO_EN;
    logic [NUM_MACRO*PSUM_W-1:0]     PSUM;

    // reduced result side
    logic                            out_valid;
    logic                            out_ready;
    logic [BIT_OUT_CH-1:0]           out_filter;
    logic [ACC_W-1:0]                out_sum;
    logic                            out_last;

    modport slave (
        input  in_valid, WHICH_FILTER, Adder_mask, MACRO_EN, PSUM, out_ready,
        output in_ready, out_valid, out_filter, out_sum, out_last
    );

    modport master (
        output in_valid, WHICH_FILTER, Adder_mask, MACRO_EN, PSUM, out_ready,
        input  in_ready, out_valid, out_filter, out_sum, out_last
    );
endinterface
`default_nettype wire

// File: rtl/adder_mask_reducer.sv
`default_nettype none
// ============================================================================
// Module      : adder_mask_reducer
// Description : Accepts one batch of macro partial sums, then emits one
//               reduced sum per filter group (head = lowest pending macro,
//               group = head plus pending macros flagged in the head's mask
//               row), one result per cycle under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_mask_reducer #(
    parameter int NUM_MACRO = 16,
    parameter int OUT_CH    = 512,
    parameter int PSUM_W    = 16
) (
    input wire                  clk,
    input wire                  rst_n,
    adder_mask_reducer_if.slave bus
);
    localparam int BIT_OUT_CH = $clog2(OUT_CH);
    localparam int ACC_W      = PSUM_W + $clog2(NUM_MACRO);
    localparam int HEAD_W     = (NUM_MACRO > 1) ? $clog2(NUM_MACRO) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]                      state_q,        state_d;
    logic [NUM_MACRO-1:0]            pending_q,      pending_d;
    logic [NUM_MACRO*BIT_OUT_CH-1:0] which_filter_q, which_filter_d;
    logic [NUM_MACRO*NUM_MACRO-1:0]  mask_q,         mask_d;
    logic [NUM_MACRO*PSUM_W-1:0]     psum_q,         psum_d;
    logic                            out_valid_q,    out_valid_d;
    logic [BIT_OUT_CH-1:0]           out_filter_q,   out_filter_d;
    logic [ACC_W-1:0]                out_sum_q,      out_sum_d;
    logic                            out_last_q,     out_last_d;

    // ------------------------------------------------------------------
    // Reduction datapath. The first group of a batch is computed straight
    // from the bus so it can be registered on the accept edge (latency 1);
    // later groups come from the stored copy of the batch.
    // ------------------------------------------------------------------
    logic                            is_idle;
    logic [NUM_MACRO-1:0]            src_pend;
    logic [NUM_MACRO*BIT_OUT_CH-1:0] src_filt;
    logic [NUM_MACRO*NUM_MACRO-1:0]  src_mask;
    logic [NUM_MACRO*PSUM_W-1:0]     src_psum;

    logic [BIT_OUT_CH-1:0]           filt_arr  [NUM_MACRO];
    logic [NUM_MACRO-1:0]            mask_rows [NUM_MACRO];
    logic [ACC_W-1:0]                psum_ext  [NUM_MACRO];

    logic [HEAD_W-1:0]               head;
    logic [NUM_MACRO-1:0]            head_row;
    logic [NUM_MACRO-1:0]            grp;
    logic [NUM_MACRO-1:0]            rest;
    logic [ACC_W-1:0]                red_sum;

    assign is_idle  = (state_q == S_IDLE);
    assign src_pend = is_idle ? bus.MACRO_EN     : pending_q;
    assign src_filt = is_idle ? bus.WHICH_FILTER : which_filter_q;
    assign src_mask = is_idle ? bus.Adder_mask   : mask_q;
    assign src_psum = is_idle ? bus.PSUM         : psum_q;

    generate
        for (genvar k = 0; k < NUM_MACRO; k++) begin : g_unpack
            assign filt_arr[k]  = src_filt[k*BIT_OUT_CH +: BIT_OUT_CH];
            assign mask_rows[k] = src_mask[k*NUM_MACRO +: NUM_MACRO];
            assign psum_ext[k]  = {{(ACC_W-PSUM_W){src_psum[k*PSUM_W+PSUM_W-1]}},
                                   src_psum[k*PSUM_W +: PSUM_W]};
        end
    endgenerate

    // Pick the head macro, build its group from the head row only (diagonal
    // forced), and add the sign-extended partial sums of the members.
    always_comb begin
        head = '0;
        for (int j = NUM_MACRO - 1; j >= 0; j--) begin
            if (src_pend[j]) begin
                head = HEAD_W'(j);
            end
        end
        head_row = mask_rows[head];
        grp      = '0;
        red_sum  = '0;
        for (int j = 0; j < NUM_MACRO; j++) begin
            grp[j] = src_pend[j] & (head_row[j] | (head == HEAD_W'(j)));
            if (grp[j]) begin
                red_sum = red_sum + psum_ext[j];
            end
        end
        rest = src_pend & ~grp;
    end

    // ------------------------------------------------------------------
    // Control: accept in IDLE, present groups in EMIT, leave after the
    // handshake of the last group.
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        which_filter_d = which_filter_q;
        mask_d         = mask_q;
        psum_d         = psum_q;
        out_valid_d    = out_valid_q;
        out_filter_d   = out_filter_q;
        out_sum_d      = out_sum_q;
        out_last_d     = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    which_filter_d = bus.WHICH_FILTER;
                    mask_d         = bus.Adder_mask;
                    psum_d         = bus.PSUM;
                    pending_d      = rest;
                    if (|bus.MACRO_EN) begin
                        state_d      = S_EMIT;
                        out_valid_d  = 1'b1;
                        out_filter_d = filt_arr[head];
                        out_sum_d    = red_sum;
                        out_last_d   = (rest == '0);
                    end
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        pending_d   = '0;
                    end else begin
                        out_filter_d = filt_arr[head];
                        out_sum_d    = red_sum;
                        out_last_d   = (rest == '0);
                        pending_d    = rest;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                pending_d   = '0;
            end
        endcase
    end

    // Register all state; reset discards any batch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pending_q      <= '0;
            which_filter_q <= '0;
            mask_q         <= '0;
            psum_q         <= '0;
            out_valid_q    <= 1'b0;
            out_filter_q   <= '0;
            out_sum_q      <= '0;
            out_last_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            which_filter_q <= which_filter_d;
            mask_q         <= mask_d;
            psum_q         <= psum_d;
            out_valid_q    <= out_valid_d;
            out_filter_q   <= out_filter_d;
            out_sum_q      <= out_sum_d;
            out_last_q     <= out_last_d;
        end
    end

    assign bus.in_ready   = is_idle;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_filter = out_filter_q;
    assign bus.out_sum    = out_sum_q;
    assign bus.out_last   = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_mask_reducer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_mask_reducer
// Description : Self-checking bench: directed and random batches, a
//               behavioural group-reduction model feeding a scoreboard, and
//               an independent monitor that checks every presented result.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adder_mask_reducer;
    localparam int NM = 16;
    localparam int OC = 512;
    localparam int PW = 16;
    localparam int BW = 9;

    typedef struct {
        int filt;
        int sum;
        bit last;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_mask_reducer_if #(.NUM_MACRO(NM), .OUT_CH(OC), .PSUM_W(PW)) bus();

    adder_mask_reducer #(.NUM_MACRO(NM), .OUT_CH(OC), .PSUM_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   bp_mode = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: repeatedly take the lowest pending macro, gather the pending
    // macros its own mask row names, add their values, retire them.
    task automatic model(input logic [NM-1:0] en, input int wf[NM],
                         input logic [NM*NM-1:0] mask, input int ps[NM]);
        logic [NM-1:0] pend;
        pend = en;
        while (pend != '0) begin
            int   h;
            res_t r;
            h = 0;
            while (!pend[h]) h++;
            r.sum = 0;
            for (int j = 0; j < NM; j++) begin
                if (pend[j] && (j == h || mask[h*NM+j])) begin
                    r.sum += ps[j];
                    pend[j] = 1'b0;
                end
            end
            r.filt = wf[h];
            r.last = (pend == '0);
            sb.push_back(r);
        end
    endtask

    task automatic scramble();
        bus.MACRO_EN = NM'($urandom);
        for (int k = 0; k < NM*NM/32; k++) bus.Adder_mask[k*32 +: 32] = $urandom;
        for (int k = 0; k < NM; k++) begin
            bus.WHICH_FILTER[k*BW +: BW] = BW'($urandom);
            bus.PSUM[k*PW +: PW]         = PW'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    // Present one batch for exactly one accepting cycle, then check latency.
    task automatic send(input logic [NM-1:0] en, input int wf[NM],
                        input logic [NM*NM-1:0] mask, input int ps[NM]);
        wait_idle();
        bus.in_valid   = 1'b1;
        bus.MACRO_EN   = en;
        bus.Adder_mask = mask;
        for (int k = 0; k < NM; k++) begin
            bus.WHICH_FILTER[k*BW +: BW] = BW'(wf[k]);
            bus.PSUM[k*PW +: PW]         = PW'(ps[k]);
        end
        model(en, wf, mask, ps);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        scramble();
        chk("latency_out_valid", longint'(bus.out_valid), (en != '0) ? 1 : 0);
    endtask

    // Downstream ready: always 1, or a coin flip each cycle.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = bp_mode ? 1'($urandom) : 1'b1;
        end
    end

    // Monitor: pops expectations on each handshake and checks stall stability,
    // continuous presentation inside a batch and the return to IDLE.
    initial begin
        bit   stall, want_idle, cont;
        int   hf, hs, hl;
        res_t e;
        stall = 0; want_idle = 0; cont = 0;
        hf = 0; hs = 0; hl = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 0; want_idle = 0; cont = 0;
                continue;
            end
            if (want_idle) begin
                chk("idle_in_ready", longint'(bus.in_ready), 1);
                chk("idle_out_valid", longint'(bus.out_valid), 0);
                want_idle = 0;
            end
            if (bus.out_valid) begin
                chk("busy_in_ready", longint'(bus.in_ready), 0);
                if (stall) begin
                    chk("stall_filter", longint'(bus.out_filter), hf);
                    chk("stall_sum", longint'($signed(bus.out_sum)), hs);
                    chk("stall_last", longint'(bus.out_last), hl);
                end
                if (bus.out_ready) begin
                    stall = 0;
                    cont  = !bus.out_last;
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_filter", longint'(bus.out_filter), e.filt);
                        chk("out_sum", longint'($signed(bus.out_sum)), e.sum);
                        chk("out_last", longint'(bus.out_last), e.last);
                        if (bus.out_last) want_idle = 1;
                    end
                end else begin
                    stall = 1;
                    cont  = 0;
                    hf = int'(bus.out_filter);
                    hs = int'($signed(bus.out_sum));
                    hl = int'(bus.out_last);
                end
            end else begin
                if (stall) chk("stall_dropped", 0, 1);
                if (cont)  chk("throughput_gap", 0, 1);
                stall = 0;
                cont  = 0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int               wf[NM];
        int               ps[NM];
        int               lbl[NM];
        logic [NM*NM-1:0] mask;
        logic [NM-1:0]    en;

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        scramble();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_out_filter", longint'(bus.out_filter), 0);
        chk("rst_out_sum", longint'(bus.out_sum), 0);
        chk("rst_out_last", longint'(bus.out_last), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All macros, one filter, all-ones mask, unit sums.
        for (int k = 0; k < NM; k++) begin wf[k] = 7; ps[k] = 1; end
        mask = '1;
        send('1, wf, mask, ps);

        // Identity mask: every macro is its own group.
        for (int k = 0; k < NM; k++) begin wf[k] = k; ps[k] = k - 8; end
        mask = '0;
        for (int k = 0; k < NM; k++) mask[k*NM+k] = 1'b1;
        send('1, wf, mask, ps);

        // Two groups {0,2} and {1,3} with extreme values.
        for (int k = 0; k < NM; k++) begin wf[k] = 0; ps[k] = 0; end
        wf[0] = 5; wf[2] = 5; wf[1] = 9; wf[3] = 9;
        ps[0] = -32768; ps[1] = -32768; ps[2] = 32767; ps[3] = 1;
        mask = '0;
        mask[0*NM+2] = 1'b1; mask[2*NM+0] = 1'b1;
        mask[1*NM+3] = 1'b1; mask[3*NM+1] = 1'b1;
        send(16'h000F, wf, mask, ps);
        // Same grouping, most-negative pair in one group.
        ps[2] = -32768;
        send(16'h000F, wf, mask, ps);
        // Empty diagonal: the head still belongs to its own group.
        mask[0*NM+0] = 1'b0;
        send(16'h000F, wf, mask, ps);

        // Empty batch: nothing emitted, stays ready.
        send('0, wf, mask, ps);
        chk("empty_in_ready", longint'(bus.in_ready), 1);
        repeat (3) @(posedge clk);
        #1;

        // Random batches: labelled groups or arbitrary (asymmetric) masks,
        // with and without backpressure.
        for (int b = 0; b < 40; b++) begin
            bp_mode = (b % 2 == 1);
            en = (b % 5 == 0) ? '1 : NM'($urandom);
            for (int k = 0; k < NM; k++) begin
                lbl[k] = $urandom_range(0, 4);
                wf[k]  = $urandom_range(0, OC - 1);
                ps[k]  = $urandom_range(0, 65535) - 32768;
            end
            if (b % 3 == 0) begin
                for (int k = 0; k < NM*NM/32; k++) mask[k*32 +: 32] = $urandom;
            end else begin
                for (int i = 0; i < NM; i++)
                    for (int j = 0; j < NM; j++)
                        mask[i*NM+j] = (lbl[i] == lbl[j]);
            end
            send(en, wf, mask, ps);
        end
        wait_idle();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while the second of four groups is on the output.
        for (int k = 0; k < NM; k++) begin wf[k] = k + 20; ps[k] = 100 * k; end
        mask = '0;
        for (int k = 0; k < NM; k++) mask[k*NM+k] = 1'b1;
        send(16'h000F, wf, mask, ps);
        @(posedge clk); #1;
        chk("pre_reset_remaining", sb.size(), 3);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_out_filter", longint'(bus.out_filter), 0);
        chk("midrst_out_sum", longint'(bus.out_sum), 0);
        chk("midrst_out_last", longint'(bus.out_last), 0);
        chk("midrst_in_ready", longint'(bus.in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_in_ready", longint'(bus.in_ready), 1);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
